// File: rtl/iicmb_wb_sequencer.sv
// Wishbone master that runs complete I2C transactions on an iicmb_m_wb controller:
// bus select (cached), START, address, data bytes, STOP, then a completion status.
module iicmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int NUM_I2C_BUSES  = 1,
  parameter int BUS_ID_WIDTH   = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int LEN_WIDTH      = 8,
  parameter int USE_IRQ        = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [BUS_ID_WIDTH-1:0]   req_bus_i,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
  input  logic                      req_rnw_i,
  input  logic [LEN_WIDTH-1:0]      req_len_i,
  input  logic                      wdata_valid_i,
  input  logic [7:0]                wdata_i,
  output logic                      wdata_ready_o,
  output logic                      rdata_valid_o,
  output logic [7:0]                rdata_o,
  input  logic                      rdata_ready_i,
  output logic                      done_o,
  output logic [1:0]                status_o,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);

  if ((2 ** BUS_ID_WIDTH) < NUM_I2C_BUSES) begin : g_bad_bus_width
    $error("BUS_ID_WIDTH too narrow for NUM_I2C_BUSES");
  end

  typedef enum logic [3:0] {
    S_ENABLE, S_IDLE, S_SETBUS_CMD, S_START, S_ADDR, S_ADDR_CMD, S_WWAIT, S_WCMD,
    S_RCMD, S_RDPR, S_RHOLD, S_STOP, S_REPORT, S_BUS, S_GAP, S_WAIT
  } state_t;

  // What to do once the current Wishbone access has been acknowledged.
  typedef enum logic [1:0] {K_PLAIN, K_CMD, K_STAT, K_DATA} kind_t;

  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

  state_t                    state, ret;
  kind_t                     kind;
  logic [2:0]                cmd;
  logic [BUS_ID_WIDTH-1:0]   bus_q, cache_bus;
  logic                      cache_ok;
  logic [I2C_ADDR_WIDTH-1:0] addr_q;
  logic                      rnw_q;
  logic [LEN_WIDTH-1:0]      cnt;
  logic [1:0]                stat;
  logic [WB_DATA_WIDTH-1:0]  rd;

  task automatic launch(input logic [WB_ADDR_WIDTH-1:0] a, input logic w,
                        input logic [WB_DATA_WIDTH-1:0] d, input kind_t k, input state_t r);
    cyc_o <= 1'b1;
    stb_o <= 1'b1;
    we_o  <= w;
    adr_o <= a;
    dat_o <= d;
    kind  <= k;
    ret   <= r;
    state <= S_BUS;
  endtask

  task automatic command(input logic [2:0] c, input state_t r);
    cmd <= c;
    launch(A_CMDR, 1'b1, WB_DATA_WIDTH'(c), K_CMD, r);
  endtask

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= S_ENABLE;
      ret           <= S_IDLE;
      kind          <= K_PLAIN;
      cmd           <= '0;
      bus_q         <= '0;
      cache_bus     <= '0;
      cache_ok      <= 1'b0;
      addr_q        <= '0;
      rnw_q         <= 1'b0;
      cnt           <= '0;
      stat          <= '0;
      rd            <= '0;
      req_ready_o   <= 1'b0;
      wdata_ready_o <= 1'b0;
      rdata_valid_o <= 1'b0;
      rdata_o       <= '0;
      done_o        <= 1'b0;
      status_o      <= '0;
      cyc_o         <= 1'b0;
      stb_o         <= 1'b0;
      we_o          <= 1'b0;
      adr_o         <= '0;
      dat_o         <= '0;
    end else begin
      done_o        <= 1'b0;
      wdata_ready_o <= 1'b0;
      case (state)
        S_ENABLE: launch(A_CSR, 1'b1, WB_DATA_WIDTH'(8'hC0), K_PLAIN, S_IDLE);
        S_IDLE: if (req_valid_i && req_ready_o) begin
          req_ready_o <= 1'b0;
          bus_q       <= req_bus_i;
          addr_q      <= req_addr_i;
          rnw_q       <= req_rnw_i;
          cnt         <= req_len_i;
          stat        <= 2'b00;
          if (cache_ok && cache_bus == req_bus_i) command(3'd4, S_ADDR);
          else launch(A_DPR, 1'b1, WB_DATA_WIDTH'(req_bus_i), K_PLAIN, S_SETBUS_CMD);
        end
        S_SETBUS_CMD: command(3'd6, S_START);
        S_START:      command(3'd4, S_ADDR);
        S_ADDR:       launch(A_DPR, 1'b1, WB_DATA_WIDTH'({addr_q, rnw_q}), K_PLAIN, S_ADDR_CMD);
        S_ADDR_CMD:   command(3'd1, (cnt == '0) ? S_STOP : (rnw_q ? S_RCMD : S_WWAIT));
        S_WWAIT: if (wdata_valid_i) begin
          wdata_ready_o <= 1'b1;
          launch(A_DPR, 1'b1, WB_DATA_WIDTH'(wdata_i), K_PLAIN, S_WCMD);
        end
        S_WCMD: begin
          cnt <= cnt - 1'b1;
          command(3'd1, (cnt == LEN_WIDTH'(1)) ? S_STOP : S_WWAIT);
        end
        S_RCMD: begin
          cnt <= cnt - 1'b1;
          command((cnt == LEN_WIDTH'(1)) ? 3'd3 : 3'd2, S_RDPR);
        end
        S_RDPR: launch(A_DPR, 1'b0, '0, K_DATA, S_RHOLD);
        // Next command waits until the consumer has taken the byte.
        S_RHOLD: if (rdata_ready_i) begin
          rdata_valid_o <= 1'b0;
          state         <= (cnt == '0) ? S_STOP : S_RCMD;
        end
        S_STOP: command(3'd5, S_REPORT);
        S_REPORT: begin
          done_o      <= 1'b1;
          status_o    <= stat;
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        S_BUS: if (ack_i) begin
          cyc_o <= 1'b0;
          stb_o <= 1'b0;
          we_o  <= 1'b0;
          rd    <= dat_i;
          state <= S_GAP;
        end
        S_GAP: case (kind)
          K_PLAIN: begin
            state <= ret;
            if (ret == S_IDLE) req_ready_o <= 1'b1;
          end
          K_CMD: begin
            if (USE_IRQ != 0) state <= S_WAIT;
            else launch(A_CMDR, 1'b0, '0, K_STAT, ret);
          end
          K_STAT: begin
            if (rd[5]) begin
              stat  <= 2'b10;
              state <= S_REPORT;
            end else if (rd[4]) begin
              stat     <= 2'b11;
              cache_ok <= 1'b0;
              state    <= S_REPORT;
            end else if (rd[6]) begin
              stat  <= 2'b01;
              state <= (cmd == 3'd5) ? S_REPORT : S_STOP;
            end else if (rd[7]) begin
              state <= ret;
              if (cmd == 3'd6) begin
                cache_ok  <= 1'b1;
                cache_bus <= bus_q;
              end
            end else if (USE_IRQ != 0) begin
              state <= S_WAIT;
            end else begin
              launch(A_CMDR, 1'b0, '0, K_STAT, ret);
            end
          end
          default: begin
            rdata_o       <= rd[7:0];
            rdata_valid_o <= 1'b1;
            state         <= ret;
          end
        endcase
        S_WAIT: if (irq_i) launch(A_CMDR, 1'b0, '0, K_STAT, ret);
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Directed bench: two sequencers (irq-driven with two buses, CMDR polling) against a
// behavioural iicmb register model with one present slave at 0x22.
module tb_iicmb_wb_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_valid[2], req_ready[2], req_rnw[2];
  logic [3:0] req_bus[2];
  logic [6:0] req_addr[2];
  logic [7:0] req_len[2];
  logic       wdata_valid[2], wdata_ready[2];
  logic [7:0] wdata[2];
  logic       rdata_valid[2], rdata_ready[2];
  logic [7:0] rdata[2];
  logic       done[2];
  logic [1:0] status[2];
  logic       cyc[2], stb[2], we[2], ack[2], irq[2];
  logic [1:0] adr[2];
  logic [7:0] dat_w[2], dat_r[2];
  logic       al_inj[2];

  int checks = 0;
  int errors = 0;

  iicmb_wb_sequencer #(.NUM_I2C_BUSES(2), .USE_IRQ(1)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_bus_i(req_bus[0]),
    .req_addr_i(req_addr[0]), .req_rnw_i(req_rnw[0]), .req_len_i(req_len[0]),
    .wdata_valid_i(wdata_valid[0]), .wdata_i(wdata[0]), .wdata_ready_o(wdata_ready[0]),
    .rdata_valid_o(rdata_valid[0]), .rdata_o(rdata[0]), .rdata_ready_i(rdata_ready[0]),
    .done_o(done[0]), .status_o(status[0]),
    .cyc_o(cyc[0]), .stb_o(stb[0]), .we_o(we[0]), .adr_o(adr[0]), .dat_o(dat_w[0]),
    .dat_i(dat_r[0]), .ack_i(ack[0]), .irq_i(irq[0])
  );

  iicmb_wb_sequencer #(.NUM_I2C_BUSES(1), .USE_IRQ(0)) dut_poll (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_bus_i(req_bus[1]),
    .req_addr_i(req_addr[1]), .req_rnw_i(req_rnw[1]), .req_len_i(req_len[1]),
    .wdata_valid_i(wdata_valid[1]), .wdata_i(wdata[1]), .wdata_ready_o(wdata_ready[1]),
    .rdata_valid_o(rdata_valid[1]), .rdata_o(rdata[1]), .rdata_ready_i(rdata_ready[1]),
    .done_o(done[1]), .status_o(status[1]),
    .cyc_o(cyc[1]), .stb_o(stb[1]), .we_o(we[1]), .adr_o(adr[1]), .dat_o(dat_w[1]),
    .dat_i(dat_r[1]), .ack_i(ack[1]), .irq_i(irq[1])
  );

  // Controller model: logs every write as {adr, data}, completes commands 6 cycles later.
  for (genvar k = 0; k < 2; k++) begin : m
    logic [7:0]  cmdr_st, dpr_w, dpr_r, rbyte, pend;
    int          cnt;
    int          cmdr_rd = 0;
    logic        first;
    logic [11:0] wq[$];
    logic [7:0]  dq[$];
    always @(posedge clk) begin
      if (rst) begin
        ack[k] <= 1'b0; irq[k] <= 1'b0; dat_r[k] <= '0;
        cmdr_st <= '0; cnt <= 0; first <= 1'b0; rbyte <= 8'h3F; dpr_r <= '0;
      end else begin
        if (cnt == 1) begin cmdr_st <= pend; irq[k] <= 1'b1; end
        if (cnt > 0) cnt <= cnt - 1;
        if (cyc[k] && stb[k] && ack[k]) begin
          ack[k] <= 1'b0;
          if (we[k]) begin
            wq.push_back({2'b00, adr[k], dat_w[k]});
            if (adr[k] == 2'd1) dpr_w <= dat_w[k];
            if (adr[k] == 2'd2) begin
              cmdr_st <= '0; irq[k] <= 1'b0; cnt <= 6; pend <= 8'h80;
              case (dat_w[k][2:0])
                3'd4: begin first <= 1'b1; if (al_inj[k]) pend <= 8'h20; end
                3'd1: if (first) begin
                  first <= 1'b0;
                  if (dpr_w[7:1] != 7'h22) pend <= 8'h40;
                end else dq.push_back(dpr_w);
                3'd2, 3'd3: begin dpr_r <= rbyte; rbyte <= rbyte - 8'd1; end
                default: ;
              endcase
            end
          end else if (adr[k] == 2'd2) begin
            cmdr_rd <= cmdr_rd + 1;
            irq[k]  <= 1'b0;
          end
        end else if (cyc[k] && stb[k]) begin
          ack[k]   <= 1'b1;
          dat_r[k] <= (adr[k] == 2'd2) ? cmdr_st : (adr[k] == 2'd1) ? dpr_r : 8'h00;
        end
      end
    end
  end

  function automatic int wlen(input int k);
    return (k == 0) ? m[0].wq.size() : m[1].wq.size();
  endfunction
  function automatic int wlog(input int k, input int i);
    return (k == 0) ? int'(m[0].wq[i]) : int'(m[1].wq[i]);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int         exp_q[$];
  logic [7:0] wbytes[4];
  int         rd_got[$];
  int         n_wready, st_got, base;

  task automatic check_log(input int k, input int b, input string tag);
    check({tag, "_nwr"}, wlen(k) - b, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), (b + i < wlen(k)) ? wlog(k, b + i) : -1, exp_q[i]);
  endtask

  task automatic do_req(input int k, input int bus, input int a, input bit rnw,
                        input int len, input int stall_idx);
    int t, wi, ri, stall, stall_base;
    bit got_done;
    wi = 0; ri = 0; stall = 0; stall_base = 0; got_done = 0;
    rd_got.delete(); n_wready = 0; st_got = -1;
    t = 0;
    while (!req_ready[k] && t < 2000) begin @(negedge clk); t++; end
    check("req_ready_wait", int'(req_ready[k]), 1);
    req_bus[k] = 4'(bus); req_addr[k] = 7'(a); req_rnw[k] = rnw; req_len[k] = 8'(len);
    req_valid[k] = 1'b1;
    if (!rnw && len > 0) begin wdata_valid[k] = 1'b1; wdata[k] = wbytes[0]; end
    @(negedge clk);
    req_valid[k] = 1'b0;
    t = 0;
    while (!got_done && t < 3000) begin
      @(negedge clk); t++;
      if (wdata_ready[k]) begin
        n_wready++; wi++;
        if (wi < len) wdata[k] = wbytes[wi]; else wdata_valid[k] = 1'b0;
      end
      rdata_ready[k] = !(ri == stall_idx && stall < 20);
      if (rdata_valid[k] && !rdata_ready[k]) begin
        if (stall == 0) stall_base = wlen(k);
        stall++;
        if (stall == 20) check("no_wr_during_stall", wlen(k) - stall_base, 0);
      end
      if (rdata_valid[k] && rdata_ready[k]) begin rd_got.push_back(int'(rdata[k])); ri++; end
      if (done[k]) begin got_done = 1; st_got = int'(status[k]); end
    end
    check("done_seen", int'(got_done), 1);
    wdata_valid[k] = 1'b0; rdata_ready[k] = 1'b0;
    @(negedge clk);
    check("done_one_cycle", int'(done[k]), 0);
    check("status_held", int'(status[k]), st_got);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 0; req_rnw[k] = 0; req_bus[k] = '0; req_addr[k] = '0; req_len[k] = '0;
      wdata_valid[k] = 0; wdata[k] = '0; rdata_ready[k] = 0; al_inj[k] = 0;
    end
    repeat (4) @(negedge clk);
    check("rst_cyc", int'(cyc[0]), 0);
    check("rst_ready", int'(req_ready[0]), 0);
    check("rst_done", int'(done[0]), 0);
    check("rst_status", int'(status[0]), 0);
    check("rst_rvalid", int'(rdata_valid[0]), 0);
    rst = 1'b0;

    // Write len=1 through a fresh bus select.
    wbytes[0] = 8'h40;
    do_req(0, 0, 'h22, 0, 1, -1);
    exp_q = '{'h0C0, 'h100, 'h206, 'h204, 'h144, 'h201, 'h140, 'h201, 'h205};
    check_log(0, 0, "t1");
    check("t1_status", st_got, 0);
    check("t1_wready", n_wready, 1);
    check("t1_i2c_byte", int'(m[0].dq[0]), 'h40);

    // Read len=3 with byte 2 stalled; bus 0 already selected.
    base = wlen(0);
    do_req(0, 0, 'h22, 1, 3, 1);
    exp_q = '{'h204, 'h145, 'h201, 'h202, 'h202, 'h203, 'h205};
    check_log(0, base, "t2");
    check("t2_status", st_got, 0);
    check("t2_nrd", rd_got.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_rd%0d", i), (i < rd_got.size()) ? rd_got[i] : -1, 'h3F - i);

    // Absent slave: address NAK, STOP, no write data taken.
    base = wlen(0);
    wbytes[0] = 8'h11; wbytes[1] = 8'h22;
    do_req(0, 0, 'h10, 0, 2, -1);
    exp_q = '{'h204, 'h120, 'h201, 'h205};
    check_log(0, base, "t3");
    check("t3_status", st_got, 1);
    check("t3_wready", n_wready, 0);
    check("t3_i2c_nbytes", m[0].dq.size(), 1);

    // Bus cache: two requests on bus 0, then bus 1.
    base = wlen(0);
    wbytes[0] = 8'h55; do_req(0, 0, 'h22, 0, 1, -1);
    wbytes[0] = 8'h66; do_req(0, 0, 'h22, 0, 1, -1);
    wbytes[0] = 8'h77; do_req(0, 1, 'h22, 0, 1, -1);
    exp_q = '{'h204, 'h144, 'h201, 'h155, 'h201, 'h205,
              'h204, 'h144, 'h201, 'h166, 'h201, 'h205,
              'h101, 'h206, 'h204, 'h144, 'h201, 'h177, 'h201, 'h205};
    check_log(0, base, "t4");
    check("t4_status", st_got, 0);
    check("t4_i2c_last", int'(m[0].dq[m[0].dq.size() - 1]), 'h77);

    // Address-only probe (len=0).
    base = wlen(0);
    do_req(0, 1, 'h22, 0, 0, -1);
    exp_q = '{'h204, 'h144, 'h201, 'h205};
    check_log(0, base, "probe");
    check("probe_status", st_got, 0);
    check("probe_wready", n_wready, 0);

    // Arbitration lost on START: no STOP, status ARB_LOST.
    base = wlen(0);
    al_inj[0] = 1'b1; wbytes[0] = 8'h88;
    do_req(0, 1, 'h22, 0, 1, -1);
    al_inj[0] = 1'b0;
    exp_q = '{'h204};
    check_log(0, base, "al");
    check("al_status", st_got, 2);
    check("al_wready", n_wready, 0);

    // Polling instance, write len=2.
    wbytes[0] = 8'hA5; wbytes[1] = 8'h5A;
    do_req(1, 0, 'h22, 0, 2, -1);
    exp_q = '{'h0C0, 'h100, 'h206, 'h204, 'h144, 'h201, 'h1A5, 'h201, 'h15A, 'h201, 'h205};
    check_log(1, 0, "poll");
    check("poll_status", st_got, 0);
    check("poll_repeat_reads", int'(m[1].cmdr_rd > 6), 1);
    check("poll_i2c_b1", int'(m[1].dq[1]), 'h5A);

    // Reset in the middle of a 4-byte write (bus 1 is cached at this point).
    for (int i = 0; i < 4; i++) wbytes[i] = 8'(i + 1);
    req_bus[0] = 4'd1; req_addr[0] = 7'h22; req_rnw[0] = 0; req_len[0] = 8'd4;
    req_valid[0] = 1'b1; wdata_valid[0] = 1'b1; wdata[0] = wbytes[0];
    @(negedge clk);
    req_valid[0] = 1'b0;
    for (int t = 0; t < 2000 && !wdata_ready[0]; t++) @(negedge clk);
    check("t6_first_byte", int'(wdata_ready[0]), 1);
    check("t6_cyc_before", int'(cyc[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_cyc_dropped", int'(cyc[0]), 0);
    check("t6_stb_dropped", int'(stb[0]), 0);
    wdata_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    base = wlen(0);
    rst = 1'b0;
    wbytes[0] = 8'h99;
    do_req(0, 1, 'h22, 0, 1, -1);
    exp_q = '{'h0C0, 'h101, 'h206, 'h204, 'h144, 'h201, 'h199, 'h201, 'h205};
    check_log(0, base, "t6");
    check("t6_status", st_got, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
